// File: rtl/axi4s_cam_out_if.sv
// AXI4-Stream pixel bus feeding axi4s_cam_out; tkeep is carried for completeness but ignored by the transmitter.
interface axi4s_cam_out_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic                    tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axi4s_cam_out.sv
// AXI4-Stream RGB -> CameraLink Base 28-bit word; beat at cycle n shows on cam_data_out at n+1, tready only in LINE/IDLE-discard.
// Defining CAM_TX_TEST_PATTERN_EN adds pattern_en for self-timed test-pattern frames (AXIS input then held off).
module axi4s_cam_out #(
  parameter int DATA_WIDTH  = 24,
  parameter int FRAME_LINES = 1080,
  parameter int LINE_PIXELS = 1920,
  parameter int FV_SETUP    = 4,
  parameter int H_BLANK     = 16,
  parameter int V_BLANK     = 64
) (
  input  logic               aclk,
  input  logic               rst,
  axi4s_cam_out_if.slave     s_axis,
`ifdef CAM_TX_TEST_PATTERN_EN
  input  logic               pattern_en,
`endif
  output logic [27:0]        cam_data_out,
  output logic               underflow,
  output logic               sync_error
);

  if (DATA_WIDTH != 24 || FRAME_LINES < 1 || FRAME_LINES > 65535 ||
      LINE_PIXELS < 1 || LINE_PIXELS > 65535 || FV_SETUP < 1 || FV_SETUP > 65535 ||
      H_BLANK < 1 || H_BLANK > 65535 || V_BLANK < 1 || V_BLANK > 65535) begin : g_param_check
    $error("axi4s_cam_out: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, SETUP, LINE, HBLANK, VBLANK} state_t;

  state_t      state;
  logic [15:0] blank_cnt;
  logic [15:0] line_cnt;
  logic        first_px;

  logic        pat;
  logic        pat_start;
  logic        pat_eol;
  logic [23:0] pat_pix;

  logic        rdy;
  logic        beat;
  logic        eol;
  logic        last_line;
  logic        underflow_c;
  logic        sync_c;
  logic        enter_vblank;
  logic [23:0] pix;
  logic        fval;
  logic        lval;

  function automatic logic [27:0] map_word(input logic f, input logic l, input logic d,
                                           input logic [23:0] px);
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic [27:0] w;
    a = px[15:8];
    b = px[7:0];
    c = px[23:16];
    w = '0;
    w[24] = l;
    w[25] = f;
    w[26] = d;
    if (d) begin
      w[4:0]   = a[4:0];
      w[6]     = a[5];
      w[27]    = a[6];
      w[5]     = a[7];
      w[9:7]   = b[2:0];
      w[14:12] = b[5:3];
      w[10]    = b[6];
      w[11]    = b[7];
      w[15]    = c[0];
      w[22:18] = c[5:1];
      w[16]    = c[6];
      w[17]    = c[7];
    end
    return w;
  endfunction

`ifdef CAM_TX_TEST_PATTERN_EN
  logic        pat_mode;
  logic [15:0] pix_cnt;
  logic [7:0]  frame_cnt;

  assign pat       = pat_mode;
  assign pat_start = pattern_en;
  assign pat_eol   = (pix_cnt == 16'(LINE_PIXELS - 1));
  assign pat_pix   = {frame_cnt, pix_cnt[7:0], line_cnt[7:0]};

  // pattern_en is only honoured in IDLE so a frame in flight keeps its source
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      pat_mode  <= 1'b0;
      pix_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      if (state == IDLE) begin
        pat_mode <= pattern_en;
        pix_cnt  <= '0;
      end else if (beat && pat_mode) begin
        pix_cnt <= eol ? 16'd0 : pix_cnt + 16'd1;
      end
      if (enter_vblank) frame_cnt <= frame_cnt + 8'd1;
    end
  end
`else
  assign pat       = 1'b0;
  assign pat_start = 1'b0;
  assign pat_eol   = 1'b0;
  assign pat_pix   = '0;
`endif

  // A tuser beat after the first of the frame is refused so it can open the next frame
  always_comb begin
    rdy = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    rdy = !s_axis.tuser && !pat_start;
        LINE:    rdy = !pat && !(s_axis.tuser && !first_px);
        default: rdy = 1'b0;
      endcase
    end
  end
  assign s_axis.tready = rdy;

  assign beat         = (state == LINE) && (pat || (s_axis.tvalid && rdy));
  assign eol          = beat && (pat ? pat_eol : s_axis.tlast);
  assign last_line    = (line_cnt == 16'(FRAME_LINES - 1));
  assign underflow_c  = (state == LINE) && !pat && !s_axis.tvalid;
  assign sync_c       = (state == LINE) && !pat && s_axis.tvalid && s_axis.tuser && !first_px;
  assign enter_vblank = sync_c || (eol && last_line);
  assign pix          = pat ? pat_pix : s_axis.tdata;
  assign fval         = (state == SETUP) || (state == LINE) || (state == HBLANK);
  assign lval         = (state == LINE);

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      blank_cnt    <= '0;
      line_cnt     <= '0;
      first_px     <= 1'b0;
      cam_data_out <= '0;
      underflow    <= 1'b0;
      sync_error   <= 1'b0;
    end else begin
      cam_data_out <= map_word(fval, lval, beat, pix);
      underflow    <= underflow_c;
      sync_error   <= sync_c;
      case (state)
        IDLE: begin
          blank_cnt <= '0;
          line_cnt  <= '0;
          if (pat_start || (s_axis.tvalid && s_axis.tuser)) begin
            state    <= SETUP;
            first_px <= 1'b1;
          end
        end
        SETUP: begin
          if (blank_cnt == 16'(FV_SETUP - 1)) begin
            blank_cnt <= '0;
            state     <= LINE;
          end else begin
            blank_cnt <= blank_cnt + 16'd1;
          end
        end
        LINE: begin
          if (sync_c) begin
            state    <= VBLANK;
            line_cnt <= '0;
            first_px <= 1'b0;
          end else if (beat) begin
            first_px <= 1'b0;
            if (eol) begin
              if (last_line) begin
                state    <= VBLANK;
                line_cnt <= '0;
              end else begin
                state    <= HBLANK;
                line_cnt <= line_cnt + 16'd1;
              end
            end
          end
        end
        HBLANK: begin
          if (blank_cnt == 16'(H_BLANK - 1)) begin
            blank_cnt <= '0;
            state     <= LINE;
          end else begin
            blank_cnt <= blank_cnt + 16'd1;
          end
        end
        VBLANK: begin
          if (blank_cnt == 16'(V_BLANK - 1)) begin
            blank_cnt <= '0;
            state     <= IDLE;
          end else begin
            blank_cnt <= blank_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4s_cam_out.sv
// Directed bench for axi4s_cam_out: FRAME_LINES=2, FV_SETUP=1, H_BLANK=2, V_BLANK=3.
module tb_axi4s_cam_out;
  logic aclk = 1'b0;
  logic rst;
  always #5 aclk = ~aclk;

  axi4s_cam_out_if #(.DATA_WIDTH(24)) s_axis ();
  logic [27:0] cam_data_out;
  logic        underflow;
  logic        sync_error;

  axi4s_cam_out #(
    .DATA_WIDTH(24), .FRAME_LINES(2), .LINE_PIXELS(4),
    .FV_SETUP(1), .H_BLANK(2), .V_BLANK(3)
  ) dut (
    .aclk(aclk),
    .rst(rst),
    .s_axis(s_axis),
`ifdef CAM_TX_TEST_PATTERN_EN
    .pattern_en(1'b0),
`endif
    .cam_data_out(cam_data_out),
    .underflow(underflow),
    .sync_error(sync_error)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic        logging = 1'b0;
  logic [27:0] log_w[$];
  logic        log_u[$];
  logic        log_s[$];

  always @(negedge aclk) begin
    if (logging) begin
      log_w.push_back(cam_data_out);
      log_u.push_back(underflow);
      log_s.push_back(sync_error);
    end
  end

  // Destination bit of each pixel bit, ports A/B/C, bit 0..7
  int a_pos[8] = '{0, 1, 2, 3, 4, 6, 27, 5};
  int b_pos[8] = '{7, 8, 9, 12, 13, 14, 10, 11};
  int c_pos[8] = '{15, 18, 19, 20, 21, 22, 16, 17};

  localparam logic [27:0] W_FV   = 28'h2000000;
  localparam logic [27:0] W_FVLV = 28'h3000000;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] cl_word(input logic f, input logic l, input logic d,
                                          input logic [23:0] px);
    logic [27:0] w;
    w = '0;
    w[24] = l;
    w[25] = f;
    w[26] = d;
    if (d) begin
      for (int i = 0; i < 8; i++) begin
        w[a_pos[i]] = px[8 + i];
        w[b_pos[i]] = px[i];
        w[c_pos[i]] = px[16 + i];
      end
    end
    return w;
  endfunction

  function automatic logic [23:0] pix(input int l, input int p);
    return 24'h3C5A96 ^ {8'(p * 17 + 1), 8'(l * 33 + p), 8'(p * 5 + l + 2)};
  endfunction

  function automatic logic [27:0] lw(input int i);
    if (i < log_w.size()) return log_w[i];
    return 28'hFFFFFFF;
  endfunction

  function automatic int count_uf();
    int n = 0;
    foreach (log_u[i]) n += int'(log_u[i]);
    return n;
  endfunction

  function automatic int count_se();
    int n = 0;
    foreach (log_s[i]) n += int'(log_s[i]);
    return n;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic start_log();
    log_w.delete();
    log_u.delete();
    log_s.delete();
    logging = 1'b1;
  endtask

  task automatic push_beat(input string tag, input logic [23:0] d, input logic u,
                           input logic l, input int budget);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    s_axis.tdata  = d;
    s_axis.tuser  = u;
    s_axis.tlast  = l;
    s_axis.tvalid = 1'b1;
    while (!acc && n < budget) begin
      @(negedge aclk);
      acc = s_axis.tready;
      @(posedge aclk);
      #1;
      n++;
    end
    s_axis.tvalid = 1'b0;
    s_axis.tuser  = 1'b0;
    s_axis.tlast  = 1'b0;
    check_val({tag, "_accept"}, 32'(acc), 32'd1);
  endtask

  task automatic gap(input int n);
    s_axis.tvalid = 1'b0;
    tick(n);
  endtask

  logic [23:0] map_d[3] = '{24'h000100, 24'h000080, 24'hFF0000};
  logic [27:0] map_e[3] = '{28'h7000001, 28'h7000800, 28'h77F8000};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] exp_w;
    rst           = 1'b1;
    s_axis.tdata  = '0;
    s_axis.tkeep  = 3'b111;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    s_axis.tuser  = 1'b0;
    s_axis.tvalid = 1'b1;
    tick(3);
    check_val("rst_word", 32'(cam_data_out), 32'd0);
    check_val("rst_uf", 32'(underflow), 32'd0);
    check_val("rst_se", 32'(sync_error), 32'd0);
    check_val("rst_ready", 32'(s_axis.tready), 32'd0);
    s_axis.tvalid = 1'b0;
    rst = 1'b0;
    tick(2);

    // Full frame: two 4-pixel lines
    start_log();
    for (int l = 0; l < 2; l++)
      for (int p = 0; p < 4; p++)
        push_beat("frm", pix(l, p), (l == 0 && p == 0), (p == 3), 20);
    tick(5);
    logging = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 2 || k == 7 || k == 8)  exp_w = W_FV;
      else if (k >= 3 && k <= 6)       exp_w = cl_word(1'b1, 1'b1, 1'b1, pix(0, k - 3));
      else if (k >= 9 && k <= 12)      exp_w = cl_word(1'b1, 1'b1, 1'b1, pix(1, k - 9));
      else                             exp_w = '0;
      check_val($sformatf("frm_w%0d", k), 32'(lw(k)), 32'(exp_w));
    end
    check_val("frm_uf_cnt", 32'(count_uf()), 32'd0);
    check_val("frm_se_cnt", 32'(count_se()), 32'd0);

    // Bit mapping, each pixel as the SoF beat of a 1-pixel-per-line frame
    for (int i = 0; i < 3; i++) begin
      start_log();
      push_beat("map_sof", map_d[i], 1'b1, 1'b1, 20);
      push_beat("map_l1", 24'h0, 1'b0, 1'b1, 20);
      tick(5);
      logging = 1'b0;
      check_val($sformatf("map%0d", i), 32'(lw(3)), 32'(map_e[i]));
    end

    // One-cycle tvalid gap mid-line
    start_log();
    push_beat("uf", pix(0, 0), 1'b1, 1'b0, 20);
    push_beat("uf", pix(0, 1), 1'b0, 1'b0, 20);
    gap(1);
    push_beat("uf", pix(0, 2), 1'b0, 1'b0, 20);
    push_beat("uf", pix(0, 3), 1'b0, 1'b1, 20);
    for (int p = 0; p < 4; p++) push_beat("uf", pix(1, p), 1'b0, (p == 3), 20);
    tick(6);
    logging = 1'b0;
    check_val("uf_w4", 32'(lw(4)), 32'(cl_word(1'b1, 1'b1, 1'b1, pix(0, 1))));
    check_val("uf_w5", 32'(lw(5)), 32'(W_FVLV));
    check_val("uf_flag5", (log_u.size() > 5) ? 32'(log_u[5]) : 32'hDEAD, 32'd1);
    check_val("uf_w6", 32'(lw(6)), 32'(cl_word(1'b1, 1'b1, 1'b1, pix(0, 2))));
    check_val("uf_w7", 32'(lw(7)), 32'(cl_word(1'b1, 1'b1, 1'b1, pix(0, 3))));
    check_val("uf_w8", 32'(lw(8)), 32'(W_FV));
    check_val("uf_cnt", 32'(count_uf()), 32'd1);

    // Mid-frame tuser on the third pixel of line 0
    start_log();
    push_beat("se", pix(2, 0), 1'b1, 1'b0, 20);
    push_beat("se", pix(2, 1), 1'b0, 1'b0, 20);
    push_beat("se_sof", pix(2, 2), 1'b1, 1'b0, 20);
    push_beat("se", pix(2, 3), 1'b0, 1'b1, 20);
    push_beat("se", pix(3, 0), 1'b0, 1'b1, 20);
    tick(6);
    logging = 1'b0;
    check_val("se_w5", 32'(lw(5)), 32'(W_FVLV));
    check_val("se_flag5", (log_s.size() > 5) ? 32'(log_s[5]) : 32'hDEAD, 32'd1);
    check_val("se_w6", 32'(lw(6)), 32'd0);
    check_val("se_w8", 32'(lw(8)), 32'd0);
    check_val("se_w9", 32'(lw(9)), 32'd0);
    check_val("se_w10", 32'(lw(10)), 32'(W_FV));
    check_val("se_w11", 32'(lw(11)), 32'(cl_word(1'b1, 1'b1, 1'b1, pix(2, 2))));
    check_val("se_cnt", 32'(count_se()), 32'd1);
    check_val("se_uf_cnt", 32'(count_uf()), 32'd0);

    // Non-SoF beats in IDLE are swallowed without output
    start_log();
    for (int i = 0; i < 3; i++) push_beat("idle", pix(4, i), 1'b0, (i == 2), 1);
    tick(2);
    logging = 1'b0;
    for (int k = 0; k < 5; k++)
      check_val($sformatf("idle_w%0d", k), 32'(lw(k)), 32'd0);

    // Asynchronous reset mid-line
    push_beat("rst", pix(5, 0), 1'b1, 1'b0, 20);
    push_beat("rst", pix(5, 1), 1'b0, 1'b0, 20);
    s_axis.tdata  = pix(5, 2);
    s_axis.tvalid = 1'b1;
    #2;
    check_val("rst_pre", 32'(cam_data_out), 32'(cl_word(1'b1, 1'b1, 1'b1, pix(5, 1))));
    rst = 1'b1;
    #1;
    check_val("rst_async_w", 32'(cam_data_out), 32'd0);
    check_val("rst_async_rdy", 32'(s_axis.tready), 32'd0);
    tick(1);
    check_val("rst_hold_w", 32'(cam_data_out), 32'd0);
    rst = 1'b0;
    s_axis.tvalid = 1'b0;
    start_log();
    push_beat("rst_drop", pix(5, 2), 1'b0, 1'b0, 1);
    push_beat("rst_drop", pix(5, 3), 1'b0, 1'b1, 1);
    tick(2);
    logging = 1'b0;
    for (int k = 0; k < 3; k++)
      check_val($sformatf("rst_drop_w%0d", k), 32'(lw(k)), 32'd0);
    start_log();
    push_beat("rst_sof", pix(6, 0), 1'b1, 1'b1, 20);
    push_beat("rst_l1", pix(6, 1), 1'b0, 1'b1, 20);
    tick(5);
    logging = 1'b0;
    check_val("rst_new_w1", 32'(lw(1)), 32'd0);
    check_val("rst_new_w2", 32'(lw(2)), 32'(W_FV));
    check_val("rst_new_w3", 32'(lw(3)), 32'(cl_word(1'b1, 1'b1, 1'b1, pix(6, 0))));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
